// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared definitions for the 640x480 VGA pixel path: active resolution,
//   colour channel width, the packed 4:4:4 colour type and motion direction.
package vga_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int RGB_W = 4;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb12_t;

  localparam rgb12_t C_BLACK = '0;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/square_mover.sv
// square_mover
//   Holds the bouncing square's top-left position and direction per axis and
//   moves it once per frame on the rising edge of the animate level.
// Ports
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_animate       end-of-frame level; only its rising edge moves the square
//   i_pause         1 suppresses motion, bounce counting and o_corner
//   o_pos_x/o_pos_y current top-left corner, 11-bit unsigned
//   o_bounce_cnt    frames with at least one wall bounce, wraps at 2^16
//   o_corner        one-cycle pulse when both axes bounce on the same tick
module square_mover
  import vga_pkg::*;
#(
  parameter int SQ_SIZE = 32,
  parameter int STEP    = 2,
  parameter int X_INIT  = 100,
  parameter int Y_INIT  = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_animate,
  input  logic        i_pause,
  output logic [10:0] o_pos_x,
  output logic [10:0] o_pos_y,
  output logic [15:0] o_bounce_cnt,
  output logic        o_corner
);

  localparam logic [10:0] LIM_X  = 11'(H_RES - SQ_SIZE);
  localparam logic [10:0] LIM_Y  = 11'(V_RES - SQ_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);

  typedef struct packed {
    logic [10:0] pos;
    dir_t        dir;
    logic        bounce;
  } axis_t;

  // One axis step; 11-bit arithmetic means pos+STEP cannot wrap.
  function automatic axis_t axis_step(input logic [10:0] pos, input dir_t dir,
                                      input logic [10:0] lim);
    axis_t r;
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (dir == DIR_POS) begin
      if (pos + STEP_W >= lim) begin
        r.pos    = lim;
        r.dir    = DIR_NEG;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos + STEP_W;
      end
    end else begin
      if (pos <= STEP_W) begin
        r.pos    = '0;
        r.dir    = DIR_POS;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos - STEP_W;
      end
    end
    return r;
  endfunction

  logic  anim_q;
  logic  tick;
  logic  move;
  dir_t  dir_x;
  dir_t  dir_y;
  axis_t nx;
  axis_t ny;

  assign tick = i_animate & ~anim_q;
  assign move = tick & ~i_pause;
  assign nx   = axis_step(o_pos_x, dir_x, LIM_X);
  assign ny   = axis_step(o_pos_y, dir_y, LIM_Y);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      anim_q       <= 1'b0;
      o_pos_x      <= 11'(X_INIT);
      o_pos_y      <= 11'(Y_INIT);
      dir_x        <= DIR_POS;
      dir_y        <= DIR_POS;
      o_bounce_cnt <= '0;
      o_corner     <= 1'b0;
    end else begin
      anim_q   <= i_animate;
      o_corner <= move & nx.bounce & ny.bounce;
      if (move) begin
        o_pos_x <= nx.pos;
        dir_x   <= nx.dir;
        o_pos_y <= ny.pos;
        dir_y   <= ny.dir;
        if (nx.bounce | ny.bounce) begin
          o_bounce_cnt <= o_bounce_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/square_animator.sv
// square_animator
//   Pixel stage after the 640x480 timing generator: moves a bouncing square
//   once per frame and renders it with registered 4:4:4 RGB and matched syncs.
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_pix_stb             pixel strobe; the render register advances on it
//   i_x, i_y, i_active    current pixel position and visible-area flag
//   i_hs, i_vs            active-low syncs, delayed one strobe to o_hs/o_vs
//   i_animate, i_pause    frame tick level and motion freeze
//   o_red/o_green/o_blue  registered colour, black outside the active area
//   o_bounce_cnt          frames with a wall bounce
//   o_corner              pulse on a simultaneous x/y bounce
module square_animator
  import vga_pkg::*;
#(
  parameter int          SQ_SIZE = 32,
  parameter int          STEP    = 2,
  parameter int          X_INIT  = 100,
  parameter int          Y_INIT  = 60,
  parameter logic [11:0] C_BOX   = 12'hF80,
  parameter logic [11:0] C_BG    = 12'h003
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  input  logic [9:0]       i_x,
  input  logic [8:0]       i_y,
  input  logic             i_active,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_animate,
  input  logic             i_pause,
  output logic [RGB_W-1:0] o_red,
  output logic [RGB_W-1:0] o_green,
  output logic [RGB_W-1:0] o_blue,
  output logic             o_hs,
  output logic             o_vs,
  output logic [15:0]      o_bounce_cnt,
  output logic             o_corner
);

  localparam logic [10:0] SQ_W = 11'(SQ_SIZE);

  logic [10:0] pos_x;
  logic [10:0] pos_y;

  square_mover #(
    .SQ_SIZE(SQ_SIZE),
    .STEP   (STEP),
    .X_INIT (X_INIT),
    .Y_INIT (Y_INIT)
  ) u_mover (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_animate   (i_animate),
    .i_pause     (i_pause),
    .o_pos_x     (pos_x),
    .o_pos_y     (pos_y),
    .o_bounce_cnt(o_bounce_cnt),
    .o_corner    (o_corner)
  );

  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo);
    return (v >= lo) && (v < lo + SQ_W);
  endfunction

  // Stage p0: colour decision from the incoming pixel and current position.
  logic   [10:0] x_p0;
  logic   [10:0] y_p0;
  logic          in_box_p0;
  rgb12_t        rgb_p0;

  assign x_p0      = {1'b0, i_x};
  assign y_p0      = {2'b0, i_y};
  assign in_box_p0 = i_active && in_span(x_p0, pos_x) && in_span(y_p0, pos_y);
  assign rgb_p0    = in_box_p0 ? rgb12_t'(C_BOX)
                   : (i_active ? rgb12_t'(C_BG) : C_BLACK);

  // Stage p1: registered colour and syncs, advanced together on the strobe.
  rgb12_t rgb_p1;
  logic   hs_p1;
  logic   vs_p1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rgb_p1 <= C_BLACK;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else if (i_pix_stb) begin
      rgb_p1 <= rgb_p0;
      hs_p1  <= i_hs;
      vs_p1  <= i_vs;
    end
  end

  assign o_red   = rgb_p1.r;
  assign o_green = rgb_p1.g;
  assign o_blue  = rgb_p1.b;
  assign o_hs    = hs_p1;
  assign o_vs    = vs_p1;

endmodule

// File: tb/tb_square_animator.sv
module tb_square_animator;
  import vga_pkg::*;

  logic       clk;
  logic       rst;
  logic       pix_stb;
  logic [9:0] x;
  logic [8:0] y;
  logic       active;
  logic       hs;
  logic       vs;
  logic       animate;
  logic       pause;

  logic [3:0]  red, green, blue;
  logic        o_hs, o_vs;
  logic [15:0] bcnt;
  logic        corner;

  logic [3:0]  c_red, c_green, c_blue;
  logic        c_hs, c_vs;
  logic [15:0] c_bcnt;
  logic        c_corner;

  int total = 0;
  int bad   = 0;

  square_animator dut (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_x(x), .i_y(y),
    .i_active(active), .i_hs(hs), .i_vs(vs), .i_animate(animate), .i_pause(pause),
    .o_red(red), .o_green(green), .o_blue(blue), .o_hs(o_hs), .o_vs(o_vs),
    .o_bounce_cnt(bcnt), .o_corner(corner)
  );

  // Second instance starting in the bottom-right corner moving (+,+).
  square_animator #(.X_INIT(608), .Y_INIT(448)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_x(x), .i_y(y),
    .i_active(active), .i_hs(hs), .i_vs(vs), .i_animate(animate), .i_pause(pause),
    .o_red(c_red), .o_green(c_green), .o_blue(c_blue), .o_hs(c_hs), .o_vs(c_vs),
    .o_bounce_cnt(c_bcnt), .o_corner(c_corner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input int hold);
    animate = 1'b1;
    repeat (hold) step();
    animate = 1'b0;
    step();
    step();
  endtask

  task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic act);
    x = px;
    y = py;
    active = act;
    pix_stb = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; pix_stb = 1'b0; x = '0; y = '0; active = 1'b0;
    hs = 1'b1; vs = 1'b1; animate = 1'b0; pause = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_rgb", {20'd0, red, green, blue}, 32'h000);
    chk("rst_hs", 32'(o_hs), 32'd1);
    chk("rst_vs", 32'(o_vs), 32'd1);
    chk("rst_cnt", 32'(bcnt), 32'd0);
    chk("rst_corner", 32'(corner), 32'd0);
    chk("rst_pos_x", 32'(dut.pos_x), 32'd100);
    chk("rst_pos_y", 32'(dut.pos_y), 32'd60);
    rst = 1'b0;
    step();

    // Rendering at the reset position; syncs lag by one strobe
    hs = 1'b0; vs = 1'b1;
    pix(10'd100, 9'd60, 1'b1);
    chk("box_tl_rgb", {20'd0, red, green, blue}, 32'hF80);
    chk("box_tl_hs", 32'(o_hs), 32'd0);
    chk("box_tl_vs", 32'(o_vs), 32'd1);
    pix_stb = 1'b0; x = '0; y = '0; hs = 1'b1; vs = 1'b0;
    step();
    chk("hold_rgb", {20'd0, red, green, blue}, 32'hF80);
    chk("hold_hs", 32'(o_hs), 32'd0);
    chk("hold_vs", 32'(o_vs), 32'd1);
    pix(10'd0, 9'd0, 1'b1);
    chk("bg_rgb", {20'd0, red, green, blue}, 32'h003);
    chk("bg_hs", 32'(o_hs), 32'd1);
    chk("bg_vs", 32'(o_vs), 32'd0);
    vs = 1'b1;
    pix(10'd131, 9'd91, 1'b1);
    chk("box_br_rgb", {20'd0, red, green, blue}, 32'hF80);
    pix(10'd132, 9'd60, 1'b1);
    chk("past_right_rgb", {20'd0, red, green, blue}, 32'h003);
    pix(10'd100, 9'd92, 1'b1);
    chk("past_bottom_rgb", {20'd0, red, green, blue}, 32'h003);
    pix(10'd99, 9'd60, 1'b1);
    chk("before_left_rgb", {20'd0, red, green, blue}, 32'h003);
    pix(10'd639, 9'd479, 1'b1);
    chk("edge_c_last_rgb", {20'd0, c_red, c_green, c_blue}, 32'hF80);
    chk("edge_main_last_rgb", {20'd0, red, green, blue}, 32'h003);
    pix(10'd607, 9'd479, 1'b1);
    chk("edge_c_607_rgb", {20'd0, c_red, c_green, c_blue}, 32'h003);
    pix(10'd100, 9'd60, 1'b0);
    chk("blank_rgb", {20'd0, red, green, blue}, 32'h000);
    pix_stb = 1'b0;

    // First tick: corner instance bounces on both axes
    animate = 1'b1;
    step();
    chk("c_corner_pulse", 32'(c_corner), 32'd1);
    chk("c_cnt", 32'(c_bcnt), 32'd1);
    chk("c_pos_x", 32'(dut_c.pos_x), 32'd608);
    chk("c_pos_y", 32'(dut_c.pos_y), 32'd448);
    chk("c_dir_x", 32'(dut_c.u_mover.dir_x), 32'(DIR_NEG));
    chk("c_dir_y", 32'(dut_c.u_mover.dir_y), 32'(DIR_NEG));
    chk("main_corner_0", 32'(corner), 32'd0);
    step();
    chk("c_corner_one_cycle", 32'(c_corner), 32'd0);
    animate = 1'b0;
    step();
    do_tick(1);
    do_tick(1);
    chk("3f_pos_x", 32'(dut.pos_x), 32'd106);
    chk("3f_pos_y", 32'(dut.pos_y), 32'd66);
    chk("3f_cnt", 32'(bcnt), 32'd0);
    chk("3f_dir_x", 32'(dut.u_mover.dir_x), 32'(DIR_POS));
    chk("3f_dir_y", 32'(dut.u_mover.dir_y), 32'(DIR_POS));
    chk("c_cnt_after3", 32'(c_bcnt), 32'd1);

    // Tick coinciding with a strobe, animate held 5 clocks
    x = 10'd106; y = 9'd66; active = 1'b1; pix_stb = 1'b1; animate = 1'b1;
    step();
    chk("coinc_rgb_pre_pos", {20'd0, red, green, blue}, 32'hF80);
    chk("coinc_pos_x", 32'(dut.pos_x), 32'd108);
    pix_stb = 1'b0;
    repeat (4) step();
    animate = 1'b0;
    step();
    step();
    chk("hold5_pos_x", 32'(dut.pos_x), 32'd108);
    chk("hold5_pos_y", 32'(dut.pos_y), 32'd68);

    // Pause over two ticks
    pause = 1'b1;
    do_tick(1);
    do_tick(1);
    chk("pause_pos_x", 32'(dut.pos_x), 32'd108);
    chk("pause_pos_y", 32'(dut.pos_y), 32'd68);
    chk("pause_cnt", 32'(bcnt), 32'd0);
    pause = 1'b0;

    // Run to x=606: 253 ticks total; y bounced at the bottom on tick 194
    for (int i = 0; i < 249; i++) do_tick(1);
    chk("x606_pos_x", 32'(dut.pos_x), 32'd606);
    chk("x606_pos_y", 32'(dut.pos_y), 32'd330);
    chk("x606_cnt", 32'(bcnt), 32'd1);
    chk("x606_dir_y", 32'(dut.u_mover.dir_y), 32'(DIR_NEG));
    animate = 1'b1;
    step();
    chk("xb_pos_x", 32'(dut.pos_x), 32'd608);
    chk("xb_pos_y", 32'(dut.pos_y), 32'd328);
    chk("xb_dir_x", 32'(dut.u_mover.dir_x), 32'(DIR_NEG));
    chk("xb_cnt", 32'(bcnt), 32'd2);
    chk("xb_corner", 32'(corner), 32'd0);
    animate = 1'b0;
    step();
    step();
    do_tick(1);
    chk("xret_pos_x", 32'(dut.pos_x), 32'd606);
    chk("xret_pos_y", 32'(dut.pos_y), 32'd326);

    // Reset mid-line takes effect without a clock edge
    hs = 1'b0;
    pix(10'd606, 9'd326, 1'b1);
    chk("pre_rst_rgb", {20'd0, red, green, blue}, 32'hF80);
    pix_stb = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rgb", {20'd0, red, green, blue}, 32'h000);
    chk("mid_rst_hs", 32'(o_hs), 32'd1);
    chk("mid_rst_vs", 32'(o_vs), 32'd1);
    chk("mid_rst_cnt", 32'(bcnt), 32'd0);
    chk("mid_rst_pos_x", 32'(dut.pos_x), 32'd100);
    chk("mid_rst_pos_y", 32'(dut.pos_y), 32'd60);
    #2;
    rst = 1'b0;
    hs = 1'b1;
    pix(10'd100, 9'd60, 1'b1);
    chk("post_rst_rgb", {20'd0, red, green, blue}, 32'hF80);
    pix_stb = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
